// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: FSM states, ALUOp codes,
// opcode/funct values and branch-condition codes.
package ctrl_pkg;

   typedef enum logic [2:0] {
      S_IF  = 3'd0,
      S_ID  = 3'd1,
      S_EX  = 3'd2,
      S_MEM = 3'd3,
      S_WB  = 3'd4
   } state_t;

   typedef enum logic [1:0] {
      BR_EQ  = 2'b00,
      BR_NE  = 2'b01,
      BR_LEZ = 2'b10,
      BR_GTZ = 2'b11
   } br_t;

   localparam int unsigned ALU_ADD    = 0;
   localparam int unsigned ALU_SUB    = 1;
   localparam int unsigned ALU_R_TYPE = 2;
   localparam int unsigned ALU_ADDIU  = 3;
   localparam int unsigned ALU_ANDI   = 4;
   localparam int unsigned ALU_SLTI   = 5;
   localparam int unsigned ALU_SLTIU  = 6;
   localparam int unsigned ALU_ORI    = 7;
   localparam int unsigned ALU_XORI   = 8;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_BLEZ  = 6'h06;
   localparam logic [5:0] OP_BGTZ  = 6'h07;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_SLTI  = 6'h0a;
   localparam logic [5:0] OP_SLTIU = 6'h0b;
   localparam logic [5:0] OP_ANDI  = 6'h0c;
   localparam logic [5:0] OP_ORI   = 6'h0d;
   localparam logic [5:0] OP_XORI  = 6'h0e;
   localparam logic [5:0] OP_LUI   = 6'h0f;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2b;

   localparam logic [5:0] FN_SLL  = 6'h00;
   localparam logic [5:0] FN_SRL  = 6'h02;
   localparam logic [5:0] FN_SRA  = 6'h03;
   localparam logic [5:0] FN_JR   = 6'h08;
   localparam logic [5:0] FN_JALR = 6'h09;

   // ALU operation for the immediate/memory group; address and addi/lui use plain add
   function automatic int unsigned imm_aluop(input logic [5:0] op);
      case (op)
         OP_ADDIU: return ALU_ADDIU;
         OP_ANDI:  return ALU_ANDI;
         OP_SLTI:  return ALU_SLTI;
         OP_SLTIU: return ALU_SLTIU;
         OP_ORI:   return ALU_ORI;
         OP_XORI:  return ALU_XORI;
         default:  return ALU_ADD;
      endcase
   endfunction

   function automatic br_t branch_type(input logic [5:0] op);
      case (op)
         OP_BNE:  return BR_NE;
         OP_BLEZ: return BR_LEZ;
         OP_BGTZ: return BR_GTZ;
         default: return BR_EQ;
      endcase
   endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode/funct classifier for the MIPS controller.
module ctrl_decode
   import ctrl_pkg::*;
#(
   parameter bit BR_EXT = 1'b1
) (
   input  logic [5:0] OpCode,
   input  logic [5:0] Funct,
   output logic       is_rtype,
   output logic       is_mem,
   output logic       is_imm_alu,
   output logic       is_branch,
   output logic       is_jump,
   output logic       is_illegal,
   output logic       is_shift,
   output logic       is_jreg
);

   always_comb begin
      is_rtype   = (OpCode == OP_RTYPE);
      is_mem     = (OpCode == OP_LW) || (OpCode == OP_SW);
      is_imm_alu = OpCode inside {OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
                                  OP_ANDI, OP_ORI, OP_XORI, OP_LUI};
      is_branch  = (OpCode == OP_BEQ) ||
                   (BR_EXT && (OpCode inside {OP_BNE, OP_BLEZ, OP_BGTZ}));
      is_jump    = (OpCode == OP_J) || (OpCode == OP_JAL);
      is_illegal = !(is_rtype || is_mem || is_imm_alu || is_branch || is_jump);
      is_shift   = is_rtype && (Funct inside {FN_SLL, FN_SRL, FN_SRA});
      is_jreg    = is_rtype && (Funct inside {FN_JR, FN_JALR});
   end

endmodule

// File: rtl/multicycle_ctrl_hs.sv
// Multi-cycle MIPS controller FSM with memory ready handshake, extended branches
// and illegal-opcode flag. Only the state register is sequential.
module multicycle_ctrl_hs
   import ctrl_pkg::*;
#(
   parameter int unsigned ALUOP_W = 4,
   parameter bit          MEM_HS  = 1'b1,
   parameter bit          BR_EXT  = 1'b1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [5:0]         OpCode,
   input  logic [5:0]         Funct,
   input  logic               mem_ready,
   output logic               PCWrite,
   output logic               PCWriteCond,
   output logic [1:0]         BranchType,
   output logic               IorD,
   output logic               MemRead,
   output logic               MemWrite,
   output logic               IRWrite,
   output logic [1:0]         MemtoReg,
   output logic [1:0]         RegDst,
   output logic               RegWrite,
   output logic               ExtOp,
   output logic               LuiOp,
   output logic [1:0]         ALUSrcA,
   output logic [1:0]         ALUSrcB,
   output logic [ALUOP_W-1:0] ALUOp,
   output logic [1:0]         PCSource,
   output logic               illegal,
   output logic [2:0]         state_o
);

   state_t state, state_nxt;
   logic   ready;
   logic   is_rtype, is_mem, is_imm_alu, is_branch, is_jump, is_illegal;
   logic   is_shift, is_jreg;

   ctrl_decode #(.BR_EXT(BR_EXT)) u_decode (
      .OpCode     (OpCode),
      .Funct      (Funct),
      .is_rtype   (is_rtype),
      .is_mem     (is_mem),
      .is_imm_alu (is_imm_alu),
      .is_branch  (is_branch),
      .is_jump    (is_jump),
      .is_illegal (is_illegal),
      .is_shift   (is_shift),
      .is_jreg    (is_jreg)
   );

   assign ready   = MEM_HS ? mem_ready : 1'b1;
   assign state_o = reset ? 3'd0 : state;

   always_ff @(posedge clk) begin
      if (reset) state <= S_IF;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt   = S_IF;
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      BranchType  = '0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      MemtoReg    = '0;
      RegDst      = '0;
      RegWrite    = 1'b0;
      ExtOp       = 1'b0;
      LuiOp       = 1'b0;
      ALUSrcA     = '0;
      ALUSrcB     = '0;
      ALUOp       = '0;
      PCSource    = '0;
      illegal     = 1'b0;
      // Reset gates every output combinationally so strobes drop in the reset cycle itself
      if (!reset) begin
         case (state)
            S_IF: begin
               MemRead = 1'b1;
               ALUSrcB = 2'b01;
               ALUOp   = ALUOP_W'(ALU_ADD);
               if (ready) begin
                  IRWrite   = 1'b1;
                  PCWrite   = 1'b1;
                  state_nxt = S_ID;
               end else begin
                  state_nxt = S_IF;
               end
            end
            S_ID: begin
               ALUSrcB = 2'b11;
               ExtOp   = 1'b1;
               ALUOp   = ALUOP_W'(ALU_ADD);
               if (is_illegal) begin
                  illegal   = 1'b1;
                  state_nxt = S_IF;
               end else begin
                  state_nxt = S_EX;
               end
            end
            S_EX: begin
               if (is_rtype) begin
                  ALUSrcA = is_shift ? 2'b10 : 2'b01;
                  ALUSrcB = 2'b00;
                  if (is_jreg) begin
                     PCWrite   = 1'b1;
                     ALUOp     = ALUOP_W'(ALU_ADD);
                     state_nxt = S_IF;
                     if (Funct == FN_JALR) begin
                        RegDst   = 2'b01;
                        MemtoReg = 2'b10;
                        RegWrite = 1'b1;
                     end
                  end else begin
                     ALUOp     = ALUOP_W'(ALU_R_TYPE);
                     state_nxt = S_WB;
                  end
               end else if (is_mem || is_imm_alu) begin
                  ALUSrcA   = 2'b01;
                  ALUSrcB   = 2'b10;
                  ExtOp     = !(OpCode inside {OP_ANDI, OP_ORI, OP_XORI});
                  LuiOp     = (OpCode == OP_LUI);
                  ALUOp     = ALUOP_W'(imm_aluop(OpCode));
                  state_nxt = is_mem ? S_MEM : S_WB;
               end else if (is_branch) begin
                  ALUSrcA     = 2'b01;
                  ALUSrcB     = 2'b00;
                  ALUOp       = ALUOP_W'(ALU_SUB);
                  PCWriteCond = 1'b1;
                  PCSource    = 2'b01;
                  BranchType  = branch_type(OpCode);
               end else if (is_jump) begin
                  PCWrite  = 1'b1;
                  PCSource = 2'b10;
                  if (OpCode == OP_JAL) begin
                     RegDst   = 2'b10;
                     MemtoReg = 2'b10;
                     RegWrite = 1'b1;
                  end
               end
            end
            S_MEM: begin
               IorD     = 1'b1;
               MemRead  = (OpCode == OP_LW);
               MemWrite = (OpCode == OP_SW);
               if (!is_mem)               state_nxt = S_IF;
               else if (!ready)           state_nxt = S_MEM;
               else if (OpCode == OP_LW)  state_nxt = S_WB;
               else                       state_nxt = S_IF;
            end
            S_WB: begin
               RegWrite = 1'b1;
               if (is_rtype) begin
                  RegDst   = 2'b01;
                  MemtoReg = 2'b01;
               end else if (is_imm_alu) begin
                  MemtoReg = 2'b01;
               end
            end
            default: state_nxt = S_IF;
         endcase
      end
   end

endmodule
